// File: rtl/imem_uart_loader.sv
// UART (8N1) program loader: packs four received bytes big-endian into one
// instruction word and writes it to instruction memory while holding the CPU.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int ADDR_W       = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    input  logic              load_en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              frame_err,
    output logic [1:0]        rx_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   WC_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

    rx_state_t         r_state;
    rx_state_t         w_next;
    logic              r_rx_meta;
    logic              r_rx_sync;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_wait_high;
    logic              w_byte_done;
    logic              w_stop_bad;
    logic              w_cnt_wrap;

    logic              r_load_q;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [23:0]       r_word;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W:0]   r_word_count;
    logic              r_full;
    logic              r_frame_err;
    logic              w_rise;
    logic              w_fall;
    logic              w_accept;
    logic [1:0]        w_idx;
    logic [ADDR_W:0]   w_wc;

    // Two-flop synchronizer, preset high so reset looks like an idle line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_byte_done = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE:  if (!r_rx_sync && !r_wait_high) w_next = S_START;
            S_START: if (r_cnt == HALF_LAST) w_next = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (r_cnt == BIT_LAST && r_bit_idx == 3'd7) w_next = S_STOP;
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_next      = S_IDLE;
                    w_byte_done = r_rx_sync;
                    w_stop_bad  = !r_rx_sync;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_cnt_wrap = (r_state == S_START) ? (r_cnt == HALF_LAST) : (r_cnt == BIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_wait_high <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_cnt_wrap) r_cnt <= '0;
            else                                 r_cnt <= r_cnt + CNT_ONE;
            if (r_state == S_IDLE) begin
                r_bit_idx <= 3'd0;
            end else if (r_state == S_DATA && r_cnt == BIT_LAST) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            // After a bad stop bit the line must return high before a new start.
            if (w_stop_bad)                          r_wait_high <= 1'b1;
            else if (r_state == S_IDLE && r_rx_sync) r_wait_high <= 1'b0;
        end
    end

    assign w_rise   = load_en && !r_load_q;
    assign w_fall   = !load_en && r_load_q;
    assign w_accept = w_byte_done && load_en;
    assign w_idx    = w_rise ? 2'd0 : r_byte_idx;
    assign w_wc     = w_rise ? '0 : r_word_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_load_q     <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_addr       <= '0;
            r_data       <= 32'd0;
            r_word       <= 24'd0;
            r_byte_idx   <= 2'd0;
            r_word_count <= '0;
            r_full       <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_load_q <= load_en;
            r_we     <= 1'b0;
            if (r_we && !w_rise) begin
                r_waddr      <= r_waddr + ADDR_ONE;
                r_word_count <= r_word_count + WC_ONE;
            end
            if (w_rise) begin
                r_waddr      <= '0;
                r_word_count <= '0;
                r_byte_idx   <= 2'd0;
                r_full       <= 1'b0;
                r_frame_err  <= 1'b0;
            end
            if (w_fall) r_byte_idx <= 2'd0;
            if (w_stop_bad) r_frame_err <= 1'b1;
            // Earlier bytes shift up; the fourth byte lands in data[7:0].
            if (w_accept) begin
                r_word     <= {r_word[15:0], r_shift};
                r_byte_idx <= w_idx + 2'd1;
                if (w_idx == 2'd3) begin
                    if (w_wc == FULL_COUNT) begin
                        r_full <= 1'b1;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= r_waddr;
                        r_data <= {r_word, r_shift};
                    end
                end
            end
        end
    end

    assign we         = r_we;
    assign addr       = r_addr;
    assign data       = r_data;
    assign cpu_hold   = r_load_q;
    assign word_count = r_word_count;
    assign full       = r_full;
    assign frame_err  = r_frame_err;
    assign rx_state   = r_state;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized bench for imem_uart_loader: UART byte driver, reference model
// of the word-packing rules, and a strobe scoreboard.
module tb_imem_uart_loader;

    localparam int CPB    = 4;
    localparam int ADDR_W = 2;
    localparam int W      = ADDR_W + 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              rx = 1'b1;
    logic              load_en = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              cpu_hold;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              frame_err;
    logic [1:0]        rx_state;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .rx(rx), .load_en(load_en),
        .we(we), .addr(addr), .data(data), .cpu_hold(cpu_hold),
        .word_count(word_count), .full(full), .frame_err(frame_err),
        .rx_state(rx_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference model: bytes of the current word, words written, flags.
    logic [W-1:0] exp_q[$];
    logic [7:0]   m_bytes[$];
    int           m_wc   = 0;
    bit           m_full = 0;
    bit           m_ferr = 0;
    bit           m_load = 0;

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] word;
        if (!m_load) return;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_bytes.delete();
            if (m_wc == (1 << ADDR_W)) m_full = 1;
            else begin
                exp_q.push_back({ADDR_W'(m_wc), word});
                m_wc++;
            end
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    logic prev_we = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            if (we) begin
                if (prev_we) check("we_width", 64'd2, 64'd1);
                if (exp_q.size() == 0) check("unexpected_we", 64'd1, 64'd0);
                else check("we_word", 64'({addr, data}), 64'(exp_q.pop_front()));
            end
            prev_we = we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        if (good_stop) model_byte(b);
        else m_ferr = 1;
        bit_time(good_stop);
        bit_time(1'b1);
        bit_time(1'b1);
    endtask

    task automatic load_set(input bit v);
        load_en = v;
        if (v && !m_load) begin
            m_bytes.delete();
            m_wc = 0; m_full = 0; m_ferr = 0;
        end
        if (!v && m_load) m_bytes.delete();
        m_load = v;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_wc"},   64'(word_count), 64'(m_wc));
        check({tag, "_full"}, 64'(full),       64'(m_full));
        check({tag, "_ferr"}, 64'(frame_err),  64'(m_ferr));
        check({tag, "_hold"}, 64'(cpu_hold),   64'(m_load));
        check({tag, "_pend"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},   64'(we),         64'd0);
        check({tag, "_addr"}, 64'(addr),       64'd0);
        check({tag, "_data"}, 64'(data),       64'd0);
        check({tag, "_hold"}, 64'(cpu_hold),   64'd0);
        check({tag, "_wc"},   64'(word_count), 64'd0);
        check({tag, "_full"}, 64'(full),       64'd0);
        check({tag, "_ferr"}, 64'(frame_err),  64'd0);
    endtask

    logic [7:0] t1[4]  = '{8'h8C, 8'h01, 8'h00, 8'h04};
    logic [7:0] t2[8]  = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10};
    logic [7:0] t4[4]  = '{8'h00, 8'h00, 8'h00, 8'h0C};

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Single word
        load_set(1);
        check("t1_hold_early", 64'(cpu_hold), 64'd1);
        foreach (t1[i]) send_byte(t1[i], 1);
        check_status("t1");
        check("t1_data_held", 64'(data), 64'h8C010004);

        // Two consecutive words in a fresh session
        load_set(0);
        load_set(1);
        foreach (t2[i]) send_byte(t2[i], 1);
        check_status("t2");

        // Glitch, framing error, then normal bytes
        load_set(0);
        load_set(1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        rx = 1'b0; #15; rx = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check_status("t3_glitch");
        send_byte(8'hE7, 0);
        check_status("t3_ferr");
        send_byte(8'h56, 1);
        send_byte(8'h78, 1);
        check_status("t3_good");

        // Partial word discarded across a load_en toggle
        load_set(0);
        load_set(1);
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 1);
        send_byte(8'hBE, 1);
        load_set(0);
        send_byte(8'h99, 1);
        check_status("t4_off");
        load_set(1);
        foreach (t4[i]) send_byte(t4[i], 1);
        check_status("t4");

        // Fill memory: the fifth word is dropped and full sticks
        load_set(0);
        load_set(1);
        for (int i = 0; i < 20; i++) send_byte(8'(i * 13 + 7), 1);
        check_status("t5");

        // Reset in the middle of bit 5 of the third byte
        load_set(0);
        load_set(1);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(1, 255)), 1);
        check_status("t6_pre");
        bit_time(1'b0);
        for (int i = 0; i < 5; i++) bit_time(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        rx = 1'b1;
        m_bytes.delete();
        m_wc = 0; m_full = 0; m_ferr = 0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1);
        check_status("t6_post");

        // Random sessions
        for (int s = 0; s < 4; s++) begin
            int nb;
            load_set(0);
            send_byte(8'($urandom_range(0, 255)), 1);
            load_set(1);
            nb = $urandom_range(3, 22);
            for (int i = 0; i < nb; i++)
                send_byte(8'($urandom), $urandom_range(0, 9) != 0);
            check_status("rnd_on");
            load_set(0);
            check_status("rnd_off");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
